fractal_sync_rx_arb: RTL and testbench
======================================

Name: fractal_sync_rx_arb

Overview:
- Ingress stage that sits directly upstream of the fractal synchronization core control.
- Collects synchronization requests from N_PORTS child/neighbour ports, round-robin arbitrates among them and buffers the winners in a FIFO.
- Presents a single valid/ready request stream to the core control, tagged with the source port index.
- Filters malformed requests and flags them.

Parameters:
- N_PORTS, 2, number of ingress request ports (>=1).
- LVL_W, 4, width of the tree-level field.
- ID_W, 8, width of the barrier-ID field.
- FIFO_DEPTH, 2, output FIFO entries (>=1).
- SRC_W, $clog2(N_PORTS) (min 1), localparam, width of the source-index field.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  N_PORTS  per-port request valid
- req_ready_o  out  N_PORTS  per-port request accepted
- req_lvl_i  in  N_PORTS*LVL_W  per-port level, port p at [p*LVL_W +: LVL_W]
- req_id_i  in  N_PORTS*ID_W  per-port barrier ID
- req_aggr_i  in  N_PORTS  per-port aggregate flag
- req_wake_i  in  N_PORTS  per-port wake flag
- out_valid_o  out  1  head FIFO entry valid
- out_ready_i  in  1  core control accepts head
- out_lvl_o  out  LVL_W  head level
- out_id_o  out  ID_W  head barrier ID
- out_aggr_o  out  1  head aggregate flag
- out_wake_o  out  1  head wake flag
- out_src_o  out  SRC_W  head source port index
- err_o  out  1  one-cycle pulse: malformed request dropped

Behaviour:
- Reset (synchronous, rst_i=1 at posedge):
  - FIFO emptied; RR pointer = 0.
  - out_valid_o=0, err_o=0, req_ready_o=0.
  - out_* data outputs = 0.
  - Reset mid-operation discards all buffered entries; no handshakes complete in the reset cycle.
- Well-formed request: exactly one of aggr/wake set.
  - aggr=wake=1 or aggr=wake=0 with valid=1 is malformed.
- Arbitration, combinational each cycle:
  - Candidates are ports with valid=1.
  - Winner = first candidate at or after the RR pointer, scanning upward with wrap N_PORTS-1 -> 0.
- Acceptance:
  - req_ready_o[winner]=1 iff FIFO not full OR (full AND out_valid_o AND out_ready_i), i.e. simultaneous pop frees a slot.
  - All other ready bits are 0.
  - At most one port is accepted per cycle.
- On an accepted handshake, the RR pointer becomes (winner+1) mod N_PORTS.
  - With no handshake, the pointer holds (no pointer movement on stall).
- Malformed winner:
  - Handshake completes (ready asserted by the same rule) and nothing is pushed.
  - err_o=1 in the next cycle.
  - Pointer advances as normal.
- Push latency: an accepted well-formed request appears at out_* on the cycle after acceptance (registered FIFO, no fall-through).
  - Minimum ingress-to-egress latency is 1 cycle.
- Output: out_* reflects the FIFO head, stable while out_valid_o=1 and out_ready_i=0. Pop occurs on out_valid_o && out_ready_i.
- Simultaneous push and pop:
  - Allowed when full or non-empty; occupancy unchanged.
  - When empty, only a push occurs.
- Occupancy counter width $clog2(FIFO_DEPTH+1); read/write pointers wrap at FIFO_DEPTH, including non-power-of-2 depths.
- No combinational path from out_ready_i to out_valid_o. The only out_ready_i -> req_ready_o path is the full-FIFO pass-through slot.
- Valid stability on ingress ports is not required: a port may drop valid without a handshake.

Optional Feature:
- Macro FSYNC_RX_ARB_STATS_EN.
- When defined, adds two outputs:
  - stall_cnt_o (32 bits): increments each cycle in which any req_valid_i=1 and no handshake occurs.
  - drop_cnt_o (16 bits): increments on each malformed drop.
- Both counters saturate at all-ones and clear on rst_i.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Single request: reset, then port0 valid lvl=3 id=0x5A aggr=1 with out_ready_i=1 -> req_ready_o[0]=1 in the same cycle; next cycle out_valid_o=1, lvl=3, id=0x5A, aggr=1, wake=0, src=0; FIFO empty after.
- Fairness: both ports continuously valid with distinct IDs, out_ready_i=1 -> accepted sources alternate 0,1,0,1 for 8 cycles; output order matches.
- Backpressure, FIFO_DEPTH=2: out_ready_i=0, port1 sends 3 requests -> first 2 accepted, third sees req_ready_o[1]=0. Raise out_ready_i -> third accepted in the same cycle as the first pop; outputs appear in order with no loss.
- Malformed: port0 aggr=1 wake=1 -> handshake completes, err_o pulses one cycle, no output entry. Next cycle a well-formed request from port1 is granted first (pointer advanced).
- Reset mid-operation: FIFO holds 2 entries, assert rst_i one cycle -> out_valid_o=0 the next cycle, pointer=0; subsequent simultaneous requests from ports 0 and 1 grant port 0 first.
- Stats (FSYNC_RX_ARB_STATS_EN): 5 stalled cycles plus 2 malformed drops -> stall_cnt_o=5, drop_cnt_o=2; force saturation -> the value holds at max.

Source files
------------

// File: rtl/fractal_sync_rx_arb.sv
// Ingress arbiter for the fractal sync core control.
// Round-robin arbitration over N_PORTS request ports into a registered FIFO
// with no fall-through. Malformed requests (aggr == wake) are accepted and
// dropped, and err_o pulses the cycle after the drop.
// Optional counters: define FSYNC_RX_ARB_STATS_EN to add stall_cnt_o and drop_cnt_o.
module fractal_sync_rx_arb #(
    parameter int unsigned N_PORTS    = 2,
    parameter int unsigned LVL_W      = 4,
    parameter int unsigned ID_W       = 8,
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned SRC_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_PORTS-1:0]       req_valid_i,
    output logic [N_PORTS-1:0]       req_ready_o,
    input  logic [N_PORTS*LVL_W-1:0] req_lvl_i,
    input  logic [N_PORTS*ID_W-1:0]  req_id_i,
    input  logic [N_PORTS-1:0]       req_aggr_i,
    input  logic [N_PORTS-1:0]       req_wake_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [LVL_W-1:0]         out_lvl_o,
    output logic [ID_W-1:0]          out_id_o,
    output logic                     out_aggr_o,
    output logic                     out_wake_o,
    output logic [SRC_W-1:0]         out_src_o,
    output logic                     err_o
`ifdef FSYNC_RX_ARB_STATS_EN
    ,
    output logic [31:0]              stall_cnt_o,
    output logic [15:0]              drop_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned ENT_W = LVL_W + ID_W + 2 + SRC_W;

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SRC_W-1:0] rr_q, win_idx, rr_next;
    logic             win_found, win_wf, slot_free, hs, push, pop, err_q;
    logic [ENT_W-1:0] win_entry, head;
    int               scan_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == int'(FIFO_DEPTH) - 1) ? '0 : p + 1'b1;
    endfunction

    // Pick the first valid port at or after the round-robin pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            scan_idx = (int'(rr_q) + i) % int'(N_PORTS);
            if (!win_found && req_valid_i[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = SRC_W'(scan_idx);
            end
        end
    end

    assign win_wf      = req_aggr_i[win_idx] ^ req_wake_i[win_idx];
    assign out_valid_o = (cnt_q != '0);
    assign pop         = out_valid_o && out_ready_i && !rst_i;
    // A full FIFO still takes a request when the head leaves in the same cycle.
    assign slot_free   = (cnt_q != CNT_W'(FIFO_DEPTH)) || (out_valid_o && out_ready_i);
    assign hs          = win_found && slot_free && !rst_i;
    assign push        = hs && win_wf;
    assign rr_next     = (int'(win_idx) == int'(N_PORTS) - 1) ? '0 : win_idx + 1'b1;

    assign win_entry = {req_lvl_i[int'(win_idx)*LVL_W +: LVL_W],
                        req_id_i[int'(win_idx)*ID_W +: ID_W],
                        req_aggr_i[win_idx], req_wake_i[win_idx], win_idx};
    assign head      = mem_q[rd_ptr_q];

    // Only the winner may see ready; everyone else waits.
    always_comb begin
        req_ready_o          = '0;
        req_ready_o[win_idx] = hs;
    end

    // Head fields are zeroed while empty so stale entries never leak out.
    assign {out_lvl_o, out_id_o, out_aggr_o, out_wake_o, out_src_o} = out_valid_o ? head : '0;
    assign err_o = err_q;

    // FIFO storage; writes only, so no reset is needed on the data array.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= win_entry;
        end
    end

    // Pointers, occupancy, round-robin pointer and the drop pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (hs) begin
                rr_q <= rr_next;
            end
            err_q <= hs && !win_wf;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!push && pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

`ifdef FSYNC_RX_ARB_STATS_EN
    logic [31:0] stall_q;
    logic [15:0] drop_q;

    // Saturating stall and malformed-drop counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            if ((|req_valid_i) && !hs && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (hs && !win_wf && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_q;
    assign drop_cnt_o  = drop_q;
`endif

endmodule

// File: tb/tb_fractal_sync_rx_arb.sv
// Scoreboard bench for fractal_sync_rx_arb: a reference model predicts grants,
// ready, err and occupancy each cycle and queues expected egress entries; a
// separate monitor pops and compares them whenever the DUT hands one out.
module tb_fractal_sync_rx_arb;

    localparam int N_PORTS    = 2;
    localparam int LVL_W      = 4;
    localparam int ID_W       = 8;
    localparam int FIFO_DEPTH = 2;
    localparam int SRC_W      = 1;

    logic                     clk = 1'b0;
    logic                     rst_i = 1'b1;
    logic [N_PORTS-1:0]       req_valid_i = '0;
    logic [N_PORTS-1:0]       req_ready_o;
    logic [N_PORTS*LVL_W-1:0] req_lvl_i = '0;
    logic [N_PORTS*ID_W-1:0]  req_id_i = '0;
    logic [N_PORTS-1:0]       req_aggr_i = '0;
    logic [N_PORTS-1:0]       req_wake_i = '0;
    logic                     out_valid_o;
    logic                     out_ready_i = 1'b0;
    logic [LVL_W-1:0]         out_lvl_o;
    logic [ID_W-1:0]          out_id_o;
    logic                     out_aggr_o;
    logic                     out_wake_o;
    logic [SRC_W-1:0]         out_src_o;
    logic                     err_o;
`ifdef FSYNC_RX_ARB_STATS_EN
    logic [31:0]              stall_cnt_o;
    logic [15:0]              drop_cnt_o;
`endif

    fractal_sync_rx_arb #(
        .N_PORTS    (N_PORTS),
        .LVL_W      (LVL_W),
        .ID_W       (ID_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_lvl_i   (req_lvl_i),
        .req_id_i    (req_id_i),
        .req_aggr_i  (req_aggr_i),
        .req_wake_i  (req_wake_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_lvl_o   (out_lvl_o),
        .out_id_o    (out_id_o),
        .out_aggr_o  (out_aggr_o),
        .out_wake_o  (out_wake_o),
        .out_src_o   (out_src_o),
        .err_o       (err_o)
`ifdef FSYNC_RX_ARB_STATS_EN
        ,
        .stall_cnt_o (stall_cnt_o),
        .drop_cnt_o  (drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LVL_W-1:0] lvl;
        logic [ID_W-1:0]  id;
        logic             aggr;
        logic             wake;
        logic [SRC_W-1:0] src;
    } entry_t;

    entry_t exp_q[$];
    int     n_cmp = 0;
    int     n_fail = 0;
    int     occ = 0;
    int     rr = 0;
    bit     err_exp = 1'b0;
    bit     after_rst = 1'b0;
    longint stall_m = 0;
    longint drop_m = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: spec rules evaluated on the inputs for the coming edge.
    always @(negedge clk) begin : model
        int            w;
        bit            pop_m, room, hs_m, mal;
        logic [N_PORTS-1:0] rdy_m;
        entry_t        e;
        w = -1;
        for (int k = 0; k < N_PORTS; k++) begin
            if (w < 0 && req_valid_i[(rr + k) % N_PORTS]) w = (rr + k) % N_PORTS;
        end
        pop_m = !rst_i && occ > 0 && out_ready_i;
        room  = (occ < FIFO_DEPTH) || pop_m;
        hs_m  = !rst_i && w >= 0 && room;
        rdy_m = '0;
        mal   = 1'b0;
        if (hs_m) begin
            rdy_m[w] = 1'b1;
            mal = (req_aggr_i[w] == req_wake_i[w]);
        end

        check("req_ready", req_ready_o, rdy_m);
        check("out_valid", out_valid_o, occ > 0);
        check("err", err_o, err_exp);
        if (after_rst) begin
            check("rst_out_lvl", out_lvl_o, 0);
            check("rst_out_id", out_id_o, 0);
        end
`ifdef FSYNC_RX_ARB_STATS_EN
        check("stall_cnt", stall_cnt_o, stall_m);
        check("drop_cnt", drop_cnt_o, drop_m);
`endif

        after_rst = rst_i;
        if (rst_i) begin
            occ = 0;
            rr = 0;
            err_exp = 1'b0;
            exp_q.delete();
            stall_m = 0;
            drop_m = 0;
        end else begin
            if (hs_m) rr = (w + 1) % N_PORTS;
            err_exp = mal;
            if ((|req_valid_i) && !hs_m && stall_m < 64'hFFFF_FFFF) stall_m++;
            if (mal && drop_m < 64'hFFFF) drop_m++;
            if (hs_m && !mal) begin
                e.lvl  = req_lvl_i[w*LVL_W +: LVL_W];
                e.id   = req_id_i[w*ID_W +: ID_W];
                e.aggr = req_aggr_i[w];
                e.wake = req_wake_i[w];
                e.src  = SRC_W'(w);
                exp_q.push_back(e);
                occ++;
            end
            if (pop_m) occ--;
        end
    end

    // Monitor: compare every egress handshake against the oldest expected entry.
    always @(negedge clk) begin : monitor
        entry_t e;
        if (!rst_i && out_valid_o === 1'b1 && out_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_pop: got an egress entry, expected none (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("out_lvl", out_lvl_o, e.lvl);
                check("out_id", out_id_o, e.id);
                check("out_aggr", out_aggr_o, e.aggr);
                check("out_wake", out_wake_o, e.wake);
                check("out_src", out_src_o, e.src);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int p, bit v, int lvl, int id, bit aggr, bit wake);
        req_valid_i[p]               = v;
        req_lvl_i[p*LVL_W +: LVL_W] = LVL_W'(lvl);
        req_id_i[p*ID_W +: ID_W]    = ID_W'(id);
        req_aggr_i[p]                = aggr;
        req_wake_i[p]                = wake;
    endtask

    task automatic idle_ports();
        for (int p = 0; p < N_PORTS; p++) drive(p, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;

        // Single request from port 0.
        out_ready_i = 1'b1;
        drive(0, 1'b1, 3, 'h5A, 1'b1, 1'b0);
        tick();
        idle_ports();
        tick();
        tick();

        // Fairness: both ports continuously valid.
        for (int k = 0; k < 8; k++) begin
            drive(0, 1'b1, k, 'h10 + k, 1'b1, 1'b0);
            drive(1, 1'b1, k, 'h20 + k, 1'b0, 1'b1);
            tick();
        end
        idle_ports();
        tick();
        tick();

        // Backpressure: fill the FIFO, then release with a pass-through slot.
        out_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1, 1'b1, 7, 'h70 + k, 1'b1, 1'b0);
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        idle_ports();
        repeat (4) tick();

        // Malformed request followed by a two-port contest.
        drive(0, 1'b1, 1, 'h33, 1'b1, 1'b1);
        tick();
        drive(0, 1'b1, 1, 'h34, 1'b1, 1'b0);
        drive(1, 1'b1, 2, 'h44, 1'b0, 1'b1);
        tick();
        idle_ports();
        drive(1, 1'b1, 2, 'h45, 1'b0, 1'b0);
        tick();
        idle_ports();
        repeat (3) tick();

        // Reset with a full FIFO.
        out_ready_i = 1'b0;
        drive(0, 1'b1, 9, 'hA0, 1'b1, 1'b0);
        tick();
        drive(1, 1'b1, 9, 'hA1, 1'b0, 1'b1);
        tick();
        idle_ports();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        drive(0, 1'b1, 4, 'hB0, 1'b1, 1'b0);
        drive(1, 1'b1, 5, 'hB1, 1'b0, 1'b1);
        tick();
        tick();
        idle_ports();
        repeat (3) tick();

        // Randomized traffic with occasional malformed requests and resets.
        repeat (3000) begin
            for (int p = 0; p < N_PORTS; p++) begin
                int r;
                bit a;
                r = $urandom_range(0, 9);
                a = 1'($urandom_range(0, 1));
                if (r == 0)      drive(p, $urandom_range(0, 3) != 0, $urandom, $urandom, 1'b1, 1'b1);
                else if (r == 1) drive(p, $urandom_range(0, 3) != 0, $urandom, $urandom, 1'b0, 1'b0);
                else             drive(p, $urandom_range(0, 3) != 0, $urandom, $urandom, a, !a);
            end
            out_ready_i = ($urandom_range(0, 9) < 7);
            rst_i = ($urandom_range(0, 199) == 0);
            tick();
        end

        // Drain and confirm nothing was lost.
        rst_i = 1'b0;
        idle_ports();
        out_ready_i = 1'b1;
        repeat (FIFO_DEPTH + 3) tick();
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
